// File: rtl/ct_f_spsram_param_if.sv
// ct_f_spsram_param_if: access bus of the parameterised single-port SRAM.
//   a         access address
//   cen       chip enable, active-low
//   gwen      global write enable, active-low
//   wen       per-bit write enable, active-low (only the top bit of each segment is sampled)
//   d         write data
//   q         read data
//   init_done array ready for user access
// master drives the access, slave is the memory.
interface ct_f_spsram_param_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 52
);
  logic [ADDR_WIDTH-1:0] a;
  logic                  cen;
  logic                  gwen;
  logic [DATA_WIDTH-1:0] wen;
  logic [DATA_WIDTH-1:0] d;
  logic [DATA_WIDTH-1:0] q;
  logic                  init_done;

  modport master (
    output a, cen, gwen, wen, d,
    input  q, init_done
  );

  modport slave (
    input  a, cen, gwen, wen, d,
    output q, init_done
  );
endinterface

// File: rtl/ct_f_spsram_param.sv
// ct_f_spsram_param: single-port SRAM model with segment write masks,
// optional output register and optional zero-fill after reset.
//   clk    single clock, all state on the rising edge
//   rst_b  asynchronous active-low reset (control/output state only)
//   bus    slave side of ct_f_spsram_param_if (a, cen, gwen, wen, d -> q, init_done)
// Read data follows an address-hold register, so a write is visible on q
// right after the write edge (write-first) and q holds while cen is high.
module ct_f_spsram_param #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 52,
  parameter int unsigned SEG_NUM    = 2,
  parameter int unsigned OUT_REG    = 0,
  parameter int unsigned INIT_EN    = 1
) (
  input  logic                 clk,
  input  logic                 rst_b,
  ct_f_spsram_param_if.slave   bus
);

  localparam int unsigned SEG_W = DATA_WIDTH / SEG_NUM;
  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2
  } state_t;

  localparam state_t RST_STATE     = (INIT_EN != 0) ? INIT : READY;
  localparam logic   RST_INIT_DONE = (INIT_EN != 0) ? 1'b0 : 1'b1;

  state_t                state_q;
  state_t                state_d;
  logic [ADDR_WIDTH-1:0] init_cnt_q;
  logic [ADDR_WIDTH-1:0] init_cnt_d;
  logic                  init_done_q;
  logic                  init_done_d;
  logic                  init_wr_c;

  logic [ADDR_WIDTH-1:0] addr_hold_q;
  logic                  rd_vld_q;
  logic                  acc_c;
  logic                  wr_c;
  logic [SEG_NUM-1:0]    seg_we_c;
  logic [DATA_WIDTH-1:0] rd_word_c;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Init FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= RST_STATE;
      init_cnt_q  <= '0;
      init_done_q <= RST_INIT_DONE;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
    end
  end

  // Init FSM next state: walk every address once, stop at the last one so the
  // counter wrap never rewrites address 0.
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    init_wr_c  = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = READY;
      end
      INIT: begin
        init_wr_c  = 1'b1;
        init_cnt_d = ADDR_WIDTH'(init_cnt_q + 1'b1);
        if (init_cnt_q == LAST_ADDR) begin
          state_d = READY;
        end
      end
      READY: begin
        state_d = READY;
      end
      default: begin
        state_d = READY;
      end
    endcase
    init_done_d = (state_d == READY);
  end

  // User access qualification and per-segment write enables.
  always_comb begin
    acc_c    = !bus.cen && init_done_q;
    wr_c     = acc_c && !bus.gwen;
    seg_we_c = '0;
    for (int unsigned k = 0; k < SEG_NUM; k++) begin
      seg_we_c[k] = wr_c && !bus.wen[(k+1)*SEG_W-1];
    end
  end

  // Storage array; deliberately has no reset.
  always_ff @(posedge clk) begin
    if (init_wr_c) begin
      mem[init_cnt_q] <= '0;
    end else begin
      for (int unsigned k = 0; k < SEG_NUM; k++) begin
        if (seg_we_c[k]) begin
          mem[bus.a][k*SEG_W +: SEG_W] <= bus.d[k*SEG_W +: SEG_W];
        end
      end
    end
  end

  // Address-hold register; rd_vld_q keeps q at zero until the first access.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      addr_hold_q <= '0;
      rd_vld_q    <= 1'b0;
    end else if (acc_c) begin
      addr_hold_q <= bus.a;
      rd_vld_q    <= 1'b1;
    end
  end

  // Array word at the held address, forced to zero while not ready.
  always_comb begin
    rd_word_c = '0;
    if (init_done_q && rd_vld_q) begin
      rd_word_c = mem[addr_hold_q];
    end
  end

  // Optional extra output stage adds one cycle of read latency.
  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] q_reg;
      always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
          q_reg <= '0;
        end else begin
          q_reg <= rd_word_c;
        end
      end
      assign bus.q = q_reg;
    end else begin : g_out_comb
      assign bus.q = rd_word_c;
    end
  endgenerate

  assign bus.init_done = init_done_q;

endmodule

// File: tb/tb_ct_f_spsram_param.sv
// Bench for ct_f_spsram_param: a default instance (zero-fill, latency 1) and a
// 64-bit/8-segment/16-deep instance (no fill, output register) run in lockstep
// against array-based reference models.
module tb_ct_f_spsram_param;

  localparam int unsigned AW0 = 8;
  localparam int unsigned DW0 = 52;
  localparam int unsigned SG0 = 2;
  localparam int unsigned SW0 = DW0 / SG0;
  localparam int unsigned AW1 = 4;
  localparam int unsigned DW1 = 64;
  localparam int unsigned SG1 = 8;
  localparam int unsigned SW1 = DW1 / SG1;

  logic clk = 1'b0;
  logic rst_b;
  always #5 clk = ~clk;

  ct_f_spsram_param_if #(.ADDR_WIDTH(AW0), .DATA_WIDTH(DW0)) bus0 ();
  ct_f_spsram_param_if #(.ADDR_WIDTH(AW1), .DATA_WIDTH(DW1)) bus1 ();

  ct_f_spsram_param #(
    .ADDR_WIDTH(AW0), .DATA_WIDTH(DW0), .SEG_NUM(SG0), .OUT_REG(0), .INIT_EN(1)
  ) u_dut0 (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus0)
  );

  ct_f_spsram_param #(
    .ADDR_WIDTH(AW1), .DATA_WIDTH(DW1), .SEG_NUM(SG1), .OUT_REG(1), .INIT_EN(0)
  ) u_dut1 (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus1)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model state.
  logic [DW0-1:0] m0 [1<<AW0];
  logic [AW0-1:0] hold0;
  bit             vld0;
  bit             done0;
  int unsigned    edges0;
  logic [DW1-1:0] m1 [1<<AW1];
  logic [AW1-1:0] hold1;
  bit             vld1;
  logic [DW1-1:0] exp_q1;
  bit             in_rst;

  // Stimulus for the next edge.
  bit             c0, g0, c1, g1;
  logic [AW0-1:0] a0;
  logic [DW0-1:0] w0, d0;
  logic [AW1-1:0] a1;
  logic [DW1-1:0] w1, d1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_reset();
    hold0  = '0;
    vld0   = 1'b0;
    done0  = 1'b0;
    edges0 = 0;
    hold1  = '0;
    vld1   = 1'b0;
    exp_q1 = '0;
  endtask

  // One clock: drive, advance the models, check both instances.
  task automatic cycle();
    bus0.cen = c0; bus0.gwen = g0; bus0.a = a0; bus0.wen = w0; bus0.d = d0;
    bus1.cen = c1; bus1.gwen = g1; bus1.a = a1; bus1.wen = w1; bus1.d = d1;
    @(posedge clk);
    if (!in_rst) begin
      if (!c0 && done0) begin
        if (!g0)
          for (int k = 0; k < SG0; k++)
            if (!w0[(k+1)*SW0-1]) m0[a0][k*SW0 +: SW0] = d0[k*SW0 +: SW0];
        hold0 = a0;
        vld0  = 1'b1;
      end
      if (!done0) begin
        edges0++;
        if (edges0 == (1 << AW0)) begin
          done0 = 1'b1;
          foreach (m0[i]) m0[i] = '0;
        end
      end
      // Output-register instance shows what the held word was before this edge.
      exp_q1 = vld1 ? m1[hold1] : '0;
      if (!c1) begin
        if (!g1)
          for (int k = 0; k < SG1; k++)
            if (!w1[(k+1)*SW1-1]) m1[a1][k*SW1 +: SW1] = d1[k*SW1 +: SW1];
        hold1 = a1;
        vld1  = 1'b1;
      end
    end
    #1;
    check("q0", 64'(bus0.q), 64'((vld0 && done0) ? m0[hold0] : '0));
    check("init_done0", 64'(bus0.init_done), 64'(done0));
    check("q1", 64'(bus1.q), exp_q1);
    check("init_done1", 64'(bus1.init_done), 64'd1);
  endtask

  task automatic rand_u1();
    c1 = ($urandom_range(0, 3) == 0);
    g1 = 1'($urandom_range(0, 1));
    w1 = {$urandom, $urandom};
    a1 = AW1'($urandom_range(0, 15));
    d1 = {$urandom, $urandom};
  endtask

  // Writes to u0 that must be ignored because it is still filling.
  task automatic ignored_u0();
    c0 = 1'b0; g0 = 1'b0; w0 = '0;
    a0 = AW0'($urandom_range(0, 255));
    d0 = DW0'({$urandom, $urandom});
  endtask

  initial begin
    rst_b = 1'b0;
    in_rst = 1'b1;
    model_reset();
    c0 = 1'b1; g0 = 1'b1; a0 = '0; w0 = '1; d0 = '0;
    c1 = 1'b1; g1 = 1'b1; a1 = '0; w1 = '1; d1 = '0;
    bus0.cen = c0; bus0.gwen = g0; bus0.a = a0; bus0.wen = w0; bus0.d = d0;
    bus1.cen = c1; bus1.gwen = g1; bus1.a = a1; bus1.wen = w1; bus1.d = d1;
    #12;
    check("rst_init_done0", 64'(bus0.init_done), 64'd0);
    check("rst_q0", 64'(bus0.q), 64'd0);
    check("rst_init_done1", 64'(bus1.init_done), 64'd1);
    check("rst_q1", 64'(bus1.q), 64'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    in_rst = 1'b0;

    // Fill phase, interrupted at counter 100; u1 gets every word written first.
    for (int i = 0; i < 100; i++) begin
      ignored_u0();
      if (i < 16) begin
        c1 = 1'b0; g1 = 1'b0; w1 = '0; a1 = AW1'(i); d1 = {$urandom, $urandom};
      end else begin
        rand_u1();
      end
      cycle();
    end

    rst_b = 1'b0;
    in_rst = 1'b1;
    model_reset();
    c1 = 1'b1;
    #1;
    check("midrst_init_done0", 64'(bus0.init_done), 64'd0);
    check("midrst_q1", 64'(bus1.q), 64'd0);
    for (int i = 0; i < 2; i++) begin
      ignored_u0();
      cycle();
    end
    rst_b = 1'b1;
    in_rst = 1'b0;

    // Restarted fill: init_done must rise on exactly the 256th edge.
    for (int i = 0; i < 256; i++) begin
      ignored_u0();
      rand_u1();
      cycle();
    end
    check("init_done_after_256", 64'(bus0.init_done), 64'd1);

    // Every u0 address reads back zero.
    for (int i = 0; i < 257; i++) begin
      c0 = (i == 256); g0 = 1'b1; w0 = '1; a0 = AW0'(i);
      rand_u1();
      cycle();
    end

    // Half-word write through the sampled segment enables.
    c1 = 1'b1;
    c0 = 1'b0; g0 = 1'b0; a0 = 8'h3C; d0 = '1;
    w0 = DW0'({$urandom, $urandom});
    w0[25] = 1'b0;
    w0[51] = 1'b1;
    cycle();
    g0 = 1'b1; w0 = '0;
    cycle();
    check("seg_write_3c", 64'(bus0.q), 64'h0_0000_03FF_FFFF);

    // Full write then hold with chip disabled.
    c0 = 1'b0; g0 = 1'b0; w0 = '0; a0 = 8'h10; d0 = 52'hA_5A5A_5A5A_5A5A;
    cycle();
    c0 = 1'b1; a0 = 8'h3C; d0 = '0;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("hold_cen1", 64'(bus0.q), 64'hA_5A5A_5A5A_5A5A);
    end

    // u1: byte-3 write into a zeroed word, latency 2 through the output register.
    c0 = 1'b1;
    c1 = 1'b0; g1 = 1'b0; w1 = '0; a1 = 4'h0; d1 = 64'h1111_2222_3333_4444;
    cycle();
    a1 = 4'hF; d1 = '0;
    cycle();
    w1 = '1; w1[31] = 1'b0; d1 = {$urandom, $urandom}; d1[31:24] = 8'hC3;
    cycle();
    g1 = 1'b1; w1 = '0; a1 = 4'h0;
    cycle();
    a1 = 4'hF;
    cycle();
    check("lat2_not_yet", bus1.q, 64'h1111_2222_3333_4444);
    c1 = 1'b1;
    cycle();
    check("byte3_f", bus1.q, 64'h0000_0000_C300_0000);

    // Random mixed traffic on both instances.
    for (int i = 0; i < 400; i++) begin
      c0 = ($urandom_range(0, 3) == 0);
      g0 = 1'($urandom_range(0, 1));
      w0 = DW0'({$urandom, $urandom});
      a0 = AW0'($urandom_range(0, 15));
      d0 = DW0'({$urandom, $urandom});
      rand_u1();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ct_f_spsram_param.md
CT_F_SPSRAM_PARAM -- requirements
Module: ct_f_spsram_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, address bits; depth = 2^ADDR_WIDTH.
REQ-002 SHALL have parameter DATA_WIDTH, default 52, word width in bits.
REQ-003 SHALL have parameter SEG_NUM, default 2, number of independently writable segments; DATA_WIDTH SHALL be divisible by SEG_NUM; SEG_W = DATA_WIDTH/SEG_NUM.
REQ-004 SHALL have parameter OUT_REG, default 0; 1 adds one registered output stage.
REQ-005 SHALL have parameter INIT_EN, default 1; 1 enables zero-fill of the whole array after reset.
REQ-006 CLK  input  1  single clock; all state on rising edge.
REQ-007 RST_B  input  1  reset, asynchronous, active-low.
REQ-008 A  input  ADDR_WIDTH  access address.
REQ-009 CEN  input  1  chip enable, active-low.
REQ-010 GWEN  input  1  global write enable, active-low.
REQ-011 WEN  input  DATA_WIDTH  per-bit write enable, active-low; only bit (k+1)*SEG_W-1 is sampled for segment k, all other bits ignored.
REQ-012 D  input  DATA_WIDTH  write data.
REQ-013 Q  output  DATA_WIDTH  read data.
REQ-014 INIT_DONE  output  1  high when the array is ready for user access.

Function
REQ-015 Access accepted on a rising edge SHALL require CEN=0 and INIT_DONE=1; otherwise A, GWEN, WEN and D SHALL be ignored.
REQ-016 Segment k SHALL be written with D[k*SEG_W +: SEG_W] on an accepted edge when GWEN=0 and WEN[(k+1)*SEG_W-1]=0.
REQ-017 Each accepted edge SHALL load the address-hold register with A; Q SHALL reflect the array contents at the held address.
REQ-018 OUT_REG=0: Q SHALL show the word at A one clock after an accepted edge (latency 1); OUT_REG=1: latency 2.
REQ-019 Write cycle SHALL be write-first: Q after the write SHALL show new data in written segments and the unchanged old data in unwritten segments.
REQ-020 With CEN=1 and no intervening write, Q SHALL hold its value indefinitely.
REQ-021 GWEN=0 with all sampled WEN bits high SHALL behave as a pure read.
REQ-022 Init FSM SHALL have states IDLE, INIT, READY; reset enters INIT when INIT_EN=1, READY when INIT_EN=0.
REQ-023 INIT SHALL write all-zero to every segment at address counter value, one address per cycle, from 0 up to 2^ADDR_WIDTH-1, then go to READY; counter wrap SHALL NOT write address 0 again.
REQ-024 INIT_DONE SHALL be 1 only in READY; with INIT_EN=1 it SHALL rise after exactly 2^ADDR_WIDTH rising edges following reset release (256 for defaults).
REQ-025 Q SHALL be forced to zero while INIT_DONE=0.
REQ-026 IDLE SHALL be unused by reset paths and SHALL transition to READY on the next edge if ever entered.
REQ-027 Array contents SHALL NOT be reset; only control and output state.

Reset
REQ-028 RST_B=0 SHALL immediately clear: address-hold register, init counter, output register (if OUT_REG=1) and Q to 0; INIT_DONE to 0 (INIT_EN=1) or 1 (INIT_EN=0).
REQ-029 Reset asserted mid-INIT SHALL restart the zero-fill from address 0 after release.
REQ-030 Reset asserted in READY SHALL abort any in-flight access; the word being written on the reset edge is undefined, all other words SHALL be preserved when INIT_EN=0.

Verification
REQ-031 Defaults, release reset, hold CEN=0 with writes -> no write lands; INIT_DONE=0 for 256 edges then 1; read of every address returns 0.
REQ-032 Defaults after init: write A=8'h3C D=52'hF_FFFF_FFFF_FFFF GWEN=0 WEN bit25=0 bit51=1 -> read A=8'h3C returns 52'h0_0000_03FF_FFFF.
REQ-033 Write A=8'h10 D=52'hA_5A5A_5A5A_5A5A all segments, then CEN=1 for 10 cycles -> Q stays 52'hA_5A5A_5A5A_5A5A for all 10 cycles.
REQ-034 OUT_REG=1, read A=8'h10 on edge n -> Q updates at edge n+2, not n+1.
REQ-035 Assert RST_B at init counter = 100 -> INIT_DONE stays 0, fill restarts at 0, INIT_DONE rises 256 edges after release.
REQ-036 DATA_WIDTH=64, SEG_NUM=8, ADDR_WIDTH=4: write byte 3 only with 8'hC3 to zeroed A=4'hF -> read returns 64'h0000_0000_C300_0000.
